ps2_note_mapper: RTL



---
 rtl/ps2_note_pkg.sv | 68 ++++++
 rtl/ps2_note_mapper_if.sv | 18 +
 rtl/note_event_fifo.sv | 66 ++++++
 rtl/ps2_note_mapper.sv | 135 +++++++++++++
 4 files changed

// File: rtl/ps2_note_pkg.sv
// ---------------------------------------------------------------------------
// ps2_note_pkg
// Shared definitions for the PS/2 note mapper:
//   - scan-code constants (prefixes, the 13 piano keys, octave keys)
//   - map_note_key(): scan code -> {hit, idx[3:0]}
//   - octave limits
//   - note_event_t: 8-bit FIFO entry {note_on, note[6:0]}
//   - kc_kind_t: classification of one keycode update
// ---------------------------------------------------------------------------
package ps2_note_pkg;

  localparam logic [7:0] SC_NONE     = 8'h00;
  localparam logic [7:0] SC_RELEASE  = 8'hF0;
  localparam logic [7:0] SC_EXTENDED = 8'hE0;
  localparam logic [7:0] SC_OCT_DOWN = 8'h1A;  // Z
  localparam logic [7:0] SC_OCT_UP   = 8'h22;  // X

  // Home-row piano layout, index order 0..12
  localparam logic [7:0] SC_A = 8'h1C, SC_W = 8'h1D, SC_S = 8'h1B, SC_E = 8'h24;
  localparam logic [7:0] SC_D = 8'h23, SC_F = 8'h2B, SC_T = 8'h2C, SC_G = 8'h34;
  localparam logic [7:0] SC_Y = 8'h35, SC_H = 8'h33, SC_U = 8'h3C, SC_J = 8'h3B;
  localparam logic [7:0] SC_K = 8'h42;

  localparam int         NUM_KEYS = 13;
  localparam logic [2:0] OCT_MIN  = 3'd1;
  localparam logic [2:0] OCT_MAX  = 3'd7;
  localparam int         EV_W     = 8;

  typedef struct packed {
    logic       note_on;
    logic [6:0] note;
  } note_event_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } key_map_t;

  typedef enum logic [1:0] {
    KC_NONE,
    KC_PRESS,
    KC_RELEASE
  } kc_kind_t;

  function automatic key_map_t map_note_key(input logic [7:0] code);
    key_map_t m;
    m.hit = 1'b1;
    m.idx = 4'd0;
    case (code)
      SC_A: m.idx = 4'd0;
      SC_W: m.idx = 4'd1;
      SC_S: m.idx = 4'd2;
      SC_E: m.idx = 4'd3;
      SC_D: m.idx = 4'd4;
      SC_F: m.idx = 4'd5;
      SC_T: m.idx = 4'd6;
      SC_G: m.idx = 4'd7;
      SC_Y: m.idx = 4'd8;
      SC_H: m.idx = 4'd9;
      SC_U: m.idx = 4'd10;
      SC_J: m.idx = 4'd11;
      SC_K: m.idx = 4'd12;
      default: m.hit = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_note_mapper_if.sv
// ---------------------------------------------------------------------------
// ps2_note_mapper_if
// Note-event valid/ready channel.
//   ev_valid   : head of the event queue holds an event
//   ev_ready   : consumer takes the head when ev_valid & ev_ready
//   ev_note_on : 1 = note-on, 0 = note-off
//   ev_note    : MIDI note number
// master = event producer (mapper), slave = event consumer.
// ---------------------------------------------------------------------------
interface ps2_note_mapper_if;
  logic       ev_valid;
  logic       ev_ready;
  logic       ev_note_on;
  logic [6:0] ev_note;

  modport master (output ev_valid, ev_note_on, ev_note, input ev_ready);
  modport slave  (input ev_valid, ev_note_on, ev_note, output ev_ready);
endinterface

// File: rtl/note_event_fifo.sv
// ---------------------------------------------------------------------------
// note_event_fifo
// Synchronous FIFO of note events; head read straight from the storage
// registers so a pushed entry is visible the cycle after the push.
//   clk, rst : clock, synchronous active-high reset
//   push,din : write request / data (accepted if not full, or full with pop)
//   full     : DEPTH entries stored
//   pop      : remove head (ignored when empty)
//   dout     : head entry, forced to 0 when empty
//   empty    : no entries stored
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module note_event_fifo
  import ps2_note_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  note_event_t din,
  output logic        full,
  input  logic        pop,
  output note_event_t dout,
  output logic        empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  note_event_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          pop_ok, push_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state is assigned with <= so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by count and
  // dout is masked when empty, so resetting every entry would buy nothing.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_note_mapper.sv
// ---------------------------------------------------------------------------
// ps2_note_mapper
// Turns PS/2 receiver keycodes into note-on/note-off events.
//   clk, rst : clock, synchronous active-high reset
//   keycode  : {prefix, scan code} from the receiver
//   ev       : event channel (master side), see ps2_note_mapper_if
//   octave   : current octave, 1..7
//   overflow : sticky, an event was dropped on a full queue
// Pipeline: keycode -> kc_q (update = kc_q != kc_prev) -> classified event
// register -> FIFO. An event reaches ev_valid three cycles after keycode.
// ---------------------------------------------------------------------------
module ps2_note_mapper
  import ps2_note_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int BASE_OCTAVE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         keycode,
  ps2_note_mapper_if.master   ev,
  output logic [2:0]          octave,
  output logic                overflow
);

  logic [15:0]   kc_q, kc_prev;
  logic [7:0]    prefix, code;
  kc_kind_t      kind;
  key_map_t      key;

  logic [NUM_KEYS-1:0] held;
  logic [6:0]          note_mem [NUM_KEYS];
  logic [6:0]          note_calc;

  logic          push_next, push_q;
  note_event_t   push_ev_next, push_ev_q;
  logic          held_set, held_clr;
  logic [2:0]    octave_next;

  logic          fifo_full, fifo_empty, pop, drop;
  note_event_t   head;

  assign prefix    = kc_q[15:8];
  assign code      = kc_q[7:0];
  assign key       = map_note_key(code);
  assign note_calc = 7'd12 * (7'(octave) + 7'd1) + 7'(key.idx);

  // NOTE: every always_comb output gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    kind = KC_NONE;
    if (kc_q != kc_prev && code != SC_NONE) begin
      if (prefix == SC_RELEASE)       kind = KC_RELEASE;
      else if (prefix != SC_EXTENDED) kind = KC_PRESS;
    end
  end

  always_comb begin
    push_next    = 1'b0;
    push_ev_next = '0;
    held_set     = 1'b0;
    held_clr     = 1'b0;
    octave_next  = octave;
    case (kind)
      KC_PRESS: begin
        // Octave keys step on every press, so receiver auto-repeats walk it.
        if (code == SC_OCT_DOWN) begin
          if (octave > OCT_MIN) octave_next = octave - 3'd1;
        end else if (code == SC_OCT_UP) begin
          if (octave < OCT_MAX) octave_next = octave + 3'd1;
        end else if (key.hit && !held[key.idx]) begin
          push_next            = 1'b1;
          push_ev_next.note_on = 1'b1;
          push_ev_next.note    = note_calc;
          held_set             = 1'b1;
        end
      end
      KC_RELEASE: begin
        // Note-off reuses the stored note so octave changes while held
        // cannot orphan the sounding note.
        if (key.hit && held[key.idx]) begin
          push_next            = 1'b1;
          push_ev_next.note_on = 1'b0;
          push_ev_next.note    = note_mem[key.idx];
          held_clr             = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign pop  = ev.ev_valid & ev.ev_ready;
  assign drop = push_q & fifo_full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      kc_q      <= '0;
      kc_prev   <= '0;
      held      <= '0;
      octave    <= 3'(BASE_OCTAVE);
      push_q    <= 1'b0;
      push_ev_q <= '0;
      overflow  <= 1'b0;
    end else begin
      kc_q      <= keycode;
      kc_prev   <= kc_q;
      push_q    <= push_next;
      push_ev_q <= push_ev_next;
      octave    <= octave_next;
      if (held_set) held[key.idx] <= 1'b1;
      if (held_clr) held[key.idx] <= 1'b0;
      if (drop)     overflow      <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (held_set) note_mem[key.idx] <= note_calc;
  end

  note_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .din   (push_ev_q),
    .full  (fifo_full),
    .pop   (pop),
    .dout  (head),
    .empty (fifo_empty)
  );

  assign ev.ev_valid   = ~fifo_empty;
  assign ev.ev_note_on = head.note_on;
  assign ev.ev_note    = head.note;

endmodule
